// File: rtl/data_serializer_pkg.sv
// Shared link definitions for the 1280 Mb/s serial link, used by the
// transmit serializer and the receive-side aligner.
package data_serializer_pkg;

   localparam int LINK_WIDTH = 32;
   localparam logic [LINK_WIDTH-1:0] LINK_IDLE_WORD = 32'hBC5A_BC5A;

   typedef logic [LINK_WIDTH-1:0] link_word_t;

   // What the output shift register does on a given edge.
   typedef enum logic [1:0] {
      LOAD_SHIFT = 2'd0,
      LOAD_HOLD  = 2'd1,
      LOAD_IDLE  = 2'd2
   } load_sel_t;

endpackage

// File: rtl/data_serializer_hold_buf.sv
// One-entry valid/ready holding buffer in front of the serializer; the
// serializer empties it with a drain strobe when it loads the held word.
module serializer_hold_buf
   import data_serializer_pkg::*;
#(
   parameter int WIDTH = LINK_WIDTH
) (
   input  logic             clk1280,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data,
   input  logic             valid,
   output logic             ready,
   input  logic             drain,
   output logic [WIDTH-1:0] hold,
   output logic             hold_full
);

   // A transfer needs an empty buffer and a drain needs a full one, so the
   // two can never happen on the same edge.
   always_ff @(posedge clk1280 or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (valid && !hold_full) begin
         hold      <= data;
         hold_full <= 1'b1;
      end else if (drain) begin
         hold_full <= 1'b0;
      end
   end

   assign ready = !hold_full;

endmodule

// File: rtl/data_serializer.sv
// 32:1 MSB-first serializer for the 1280 Mb/s link; inserts the idle word
// whenever no user word is waiting at a word boundary.
module data_serializer
   import data_serializer_pkg::*;
#(
   parameter int               WIDTH     = LINK_WIDTH,
   parameter logic [WIDTH-1:0] IDLE_WORD = LINK_IDLE_WORD
) (
   input  logic             clk1280,
   input  logic             rst_n,
   input  logic             Enable,
   input  logic [WIDTH-1:0] Data,
   input  logic             Valid,
   output logic             Ready,
   output logic             Tx,
   output logic             WordStart,
   output logic             Underrun
);

   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             drain;
   logic             underrun_q;
   logic             underrun_next;
   logic             boundary;
   load_sel_t        load_sel;

   serializer_hold_buf #(
      .WIDTH     (WIDTH)
   ) u_hold_buf (
      .clk1280   (clk1280),
      .rst_n     (rst_n),
      .data      (Data),
      .valid     (Valid),
      .ready     (Ready),
      .drain     (drain),
      .hold      (hold),
      .hold_full (hold_full)
   );

   assign boundary = (cnt == CNT_LAST);

   // Enable is only looked at on the boundary edge, so a mid-word change
   // never cuts a word short.
   always_comb begin
      load_sel      = LOAD_SHIFT;
      drain         = 1'b0;
      underrun_next = 1'b0;
      if (boundary) begin
         if (Enable && hold_full) begin
            load_sel = LOAD_HOLD;
            drain    = 1'b1;
         end else begin
            load_sel      = LOAD_IDLE;
            underrun_next = Enable;
         end
      end
   end

   always_comb begin
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
      cnt_next   = cnt + CNT_W'(1);
      case (load_sel)
         LOAD_HOLD: begin
            shreg_next = hold;
            cnt_next   = '0;
         end
         LOAD_IDLE: begin
            shreg_next = IDLE_WORD;
            cnt_next   = '0;
         end
         default: begin
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
            cnt_next   = cnt + CNT_W'(1);
         end
      endcase
   end

   always_ff @(posedge clk1280 or negedge rst_n) begin
      if (!rst_n) begin
         shreg      <= IDLE_WORD;
         cnt        <= '0;
         underrun_q <= 1'b0;
      end else begin
         shreg      <= shreg_next;
         cnt        <= cnt_next;
         underrun_q <= underrun_next;
      end
   end

   assign Tx        = shreg[WIDTH-1];
   assign WordStart = (cnt == '0);
   assign Underrun  = underrun_q;

endmodule

// File: tb/tb_data_serializer.sv
// Self-checking bench for data_serializer: word-level reference model
// (current word, bit position, holding queue) compared every cycle.
module tb_data_serializer;
   import data_serializer_pkg::*;

   localparam int             W    = LINK_WIDTH;
   localparam logic [W-1:0]   IDLE = LINK_IDLE_WORD;

   logic         clk1280 = 1'b0;
   logic         rst_n   = 1'b0;
   logic         Enable  = 1'b0;
   logic         Valid   = 1'b0;
   logic [W-1:0] Data    = '0;
   logic         Ready;
   logic         Tx;
   logic         WordStart;
   logic         Underrun;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: the word on the wire, which bit of it is showing,
   // the words waiting in the buffer, and whether an underrun is flagged.
   logic [W-1:0] mWord;
   int           mPos;
   logic         mUnder;
   logic [W-1:0] mHold[$];
   logic [W-1:0] txQ[$];

   always #5 clk1280 = ~clk1280;

   data_serializer dut (
      .clk1280   (clk1280),
      .rst_n     (rst_n),
      .Enable    (Enable),
      .Data      (Data),
      .Valid     (Valid),
      .Ready     (Ready),
      .Tx        (Tx),
      .WordStart (WordStart),
      .Underrun  (Underrun)
   );

   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mWord  = IDLE;
      mPos   = 0;
      mUnder = 1'b0;
      mHold.delete();
   endtask

   task automatic checkAll();
      logic [W-1:0] w;
      w = mWord;
      checkOutput("tx", W'(Tx), W'(w[W-1-mPos]));
      checkOutput("wordstart", W'(WordStart), W'(mPos == 0));
      checkOutput("ready", W'(Ready), W'(mHold.size() == 0));
      checkOutput("underrun", W'(Underrun), W'(mUnder));
   endtask

   // One clock edge of the link, evaluated with the inputs the DUT will sample.
   task automatic modelEdge();
      bit fire;
      fire = Valid && (mHold.size() == 0);
      if (mPos == W - 1) begin
         mPos = 0;
         if (Enable && mHold.size() > 0) begin
            mWord  = mHold.pop_front();
            mUnder = 1'b0;
         end else begin
            mWord  = IDLE;
            mUnder = Enable;
         end
      end else begin
         mPos++;
         mUnder = 1'b0;
      end
      if (fire) begin
         mHold.push_back(Data);
         void'(txQ.pop_front());
      end
   endtask

   task automatic applyStimulus(input logic en);
      Enable = en;
      Valid  = (txQ.size() > 0);
      Data   = Valid ? txQ[0] : W'($urandom);
      modelEdge();
      @(posedge clk1280);
      @(negedge clk1280);
      checkAll();
   endtask

   task automatic doReset(input int cycles);
      rst_n = 1'b0;
      Valid = 1'b0;
      txQ.delete();
      modelReset();
      #1;
      checkOutput("rst_tx", W'(Tx), W'(1'b1));
      checkOutput("rst_ready", W'(Ready), W'(1'b1));
      checkOutput("rst_wordstart", W'(WordStart), W'(1'b1));
      checkOutput("rst_underrun", W'(Underrun), W'(1'b0));
      repeat (cycles) @(negedge clk1280);
      checkOutput("rst_hold_tx", W'(Tx), W'(1'b1));
      checkOutput("rst_hold_ready", W'(Ready), W'(1'b1));
      rst_n = 1'b1;
   endtask

   task automatic waitPos(input int target, input logic en);
      int n;
      n = 0;
      while (mPos != target && n < 100) begin
         applyStimulus(en);
         n++;
      end
      if (mPos != target) checkOutput("wait_pos", W'(mPos), W'(target));
   endtask

   task automatic runCycles(input int n, input logic en);
      for (int i = 0; i < n; i++) applyStimulus(en);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic en;
      modelReset();
      @(negedge clk1280);
      doReset(3);

      // Single word one cycle after reset
      applyStimulus(1'b1);
      txQ.push_back(32'hA5A5_0F0F);
      runCycles(100, 1'b1);

      // Back-to-back words with Valid held high
      waitPos(5, 1'b1);
      txQ.push_back(32'h0000_0001);
      txQ.push_back(32'h8000_0000);
      txQ.push_back(32'hFFFF_FFFF);
      runCycles(140, 1'b1);

      // Word presented exactly on the boundary edge with the buffer empty
      waitPos(W - 1, 1'b1);
      txQ.push_back(32'h1234_5678);
      runCycles(80, 1'b1);

      // Enable low for three words with a word parked in the buffer
      waitPos(2, 1'b1);
      txQ.push_back(32'hDEAD_BEEF);
      applyStimulus(1'b0);
      checkOutput("hold_parked_ready", W'(Ready), W'(1'b0));
      runCycles(3 * W + 20, 1'b0);
      runCycles(80, 1'b1);

      // Reset mid-word while a word waits in the buffer
      waitPos(1, 1'b1);
      txQ.push_back(32'h5555_AAAA);
      waitPos(10, 1'b1);
      checkOutput("pre_rst_ready", W'(Ready), W'(1'b0));
      doReset(2);
      runCycles(80, 1'b1);

      // Randomized traffic with occasional Enable changes and one reset
      en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (txQ.size() < 3 && $urandom_range(0, 24) == 0) begin
            txQ.push_back(W'($urandom));
            if ($urandom_range(0, 3) == 0) txQ.push_back(W'($urandom));
         end
         if ($urandom_range(0, 149) == 0) en = ~en;
         if (i == 1500) doReset(2);
         applyStimulus(en);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
